// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and default sizing.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  localparam int unsigned DEF_OVERSAMPLE = 16;
  localparam int unsigned DEF_DATA_BITS  = 8;

  // Mode 3 is an alias for "no parity".
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Receive-word handshake and error strobes between uart_rx_os and its consumer.
interface uart_rx_os_if #(
  parameter int unsigned DATA_BITS = uart_pkg::DEF_DATA_BITS
);
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 data_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output data, data_valid, parity_err, frame_err, overrun,
    input  data_ready
  );

  modport slave (
    input  data, data_valid, parity_err, frame_err, overrun,
    output data_ready
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// rx synchroniser, per-bit oversample counter and 3-sample majority vote.
module uart_rx_sampler #(
  parameter int unsigned OVERSAMPLE = uart_pkg::DEF_OVERSAMPLE
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic clr,      // hold the bit counter at 0 (receiver idle)
  input  logic rx,
  output logic rx_s,
  output logic bit_val,  // majority of the three centre samples
  output logic decide,   // tick on which bit_val is valid
  output logic wrap      // last tick of the current bit
);

  localparam int unsigned CW  = $clog2(OVERSAMPLE);
  localparam int unsigned MID = OVERSAMPLE / 2;

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s_a_q, s_a_d;
  logic          s_b_q, s_b_d;

  assign rx_s    = sync_q[1];
  assign decide  = tick && (cnt_q == CW'(MID + 1));
  assign wrap    = tick && (cnt_q == CW'(OVERSAMPLE - 1));
  // Third sample is taken live at the decision tick.
  assign bit_val = (s_a_q & s_b_q) | (s_a_q & rx_s) | (s_b_q & rx_s);

  // Next-state for synchroniser, bit counter and the two stored samples.
  always_comb begin
    sync_d = {sync_q[0], rx};
    cnt_d  = cnt_q;
    s_a_d  = s_a_q;
    s_b_d  = s_b_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = (cnt_q == CW'(OVERSAMPLE - 1)) ? '0 : cnt_q + CW'(1);
      if (cnt_q == CW'(MID - 1)) s_a_d = rx_s;
      if (cnt_q == CW'(MID))     s_b_d = rx_s;
    end
  end

  // Register update with synchronous reset; the line idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      s_a_q  <= 1'b1;
      s_b_q  <= 1'b1;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      s_a_q  <= s_a_d;
      s_b_q  <= s_b_d;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: frame FSM plus valid/ready output stage.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         enable,
  input  logic [1:0]   parity_mode,
  input  logic         rx,
  output logic         busy,
  uart_rx_os_if.master bus
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  rx_state_t            state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [1:0]           mode_q, mode_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d;
  logic                 done_q, done_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 pe_pulse_q, pe_pulse_d;
  logic                 fe_pulse_q, fe_pulse_d;
  logic                 ov_pulse_q, ov_pulse_d;

  logic rx_s, bit_val, decide, wrap;

  uart_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .clr    (state_d == IDLE),
    .rx     (rx),
    .rx_s   (rx_s),
    .bit_val(bit_val),
    .decide (decide),
    .wrap   (wrap)
  );

  assign busy           = (state_q != IDLE);
  assign bus.data       = data_q;
  assign bus.data_valid = valid_q;
  assign bus.parity_err = pe_pulse_q;
  assign bus.frame_err  = fe_pulse_q;
  assign bus.overrun    = ov_pulse_q;

  // Frame FSM: walks start/data/parity/stop on sampler strobes.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    mode_d  = mode_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    done_d  = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          // The detect tick is counted as tick 0 of the start bit.
          if (tick && !rx_s) begin
            state_d = START;
            mode_d  = parity_mode;
            pe_d    = 1'b0;
            fe_d    = 1'b0;
            idx_d   = '0;
          end
        end
        START: begin
          if (decide && bit_val) begin
            state_d = IDLE;
          end else if (wrap) begin
            state_d = DATA;
            idx_d   = '0;
          end
        end
        DATA: begin
          if (decide) sh_d = {bit_val, sh_q[DATA_BITS-1:1]};
          if (wrap) begin
            if (idx_q == LAST_DATA) begin
              state_d = parity_enabled(mode_q) ? PARITY : STOP;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
        PARITY: begin
          if (decide) begin
            if (mode_q == PAR_ODD) pe_d = ((^sh_q) == bit_val);
            else                   pe_d = ((^sh_q) != bit_val);
          end
          if (wrap) begin
            state_d = STOP;
            idx_d   = '0;
          end
        end
        STOP: begin
          if (decide) begin
            if (!bit_val) fe_d = 1'b1;
            // Leave at the final decision so a following start edge is caught early.
            if (idx_q == LAST_STOP) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else if (wrap) begin
            idx_d = idx_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output stage: per-clk handshake and frame completion one clk after the final decision.
  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    pe_pulse_d = 1'b0;
    fe_pulse_d = 1'b0;
    ov_pulse_d = 1'b0;
    if (valid_q && bus.data_ready) valid_d = 1'b0;
    if (done_q) begin
      if (fe_q) begin
        fe_pulse_d = 1'b1;
      end else if (valid_q && !bus.data_ready) begin
        ov_pulse_d = 1'b1;
      end else begin
        data_d     = sh_q;
        valid_d    = 1'b1;
        pe_pulse_d = pe_q;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      sh_q       <= '0;
      mode_q     <= PAR_NONE;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      pe_pulse_q <= 1'b0;
      fe_pulse_q <= 1'b0;
      ov_pulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sh_q       <= sh_d;
      mode_q     <= mode_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
      done_q     <= done_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      pe_pulse_q <= pe_pulse_d;
      fe_pulse_q <= fe_pulse_d;
      ov_pulse_q <= ov_pulse_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: directed table, corner sequences, random frames.
module tb_uart_rx_os;

  localparam int unsigned OS = 16;
  localparam int unsigned DB = 8;
  localparam int unsigned SB = 1;

  logic       clk = 1'b0;
  logic       rst, tick, enable, rx, busy;
  logic [1:0] parity_mode;

  uart_rx_os_if #(.DATA_BITS(DB)) bus ();

  uart_rx_os #(
    .OVERSAMPLE(OS),
    .DATA_BITS (DB),
    .STOP_BITS (SB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .enable     (enable),
    .parity_mode(parity_mode),
    .rx         (rx),
    .busy       (busy),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Oversample strobe: high on every other clk.
  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = ~tick;
    end
  end

  // Event counters for the one-clk pulses and rising edges.
  int unsigned pe_n = 0, fe_n = 0, ov_n = 0, dv_n = 0, bz_n = 0;
  logic dv_p = 1'b0, bz_p = 1'b0;
  always @(negedge clk) begin
    if (bus.parity_err === 1'b1) pe_n++;
    if (bus.frame_err  === 1'b1) fe_n++;
    if (bus.overrun    === 1'b1) ov_n++;
    if (bus.data_valid === 1'b1 && !dv_p) dv_n++;
    if (busy === 1'b1 && !bz_p) bz_n++;
    dv_p = (bus.data_valid === 1'b1);
    bz_p = (busy === 1'b1);
  end

  int unsigned n_chk = 0, n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      do @(posedge clk); while (tick !== 1'b1);
    end
    #1;
  endtask

  task automatic build_frame(input logic [7:0] d, input logic [1:0] mode, input bit bad,
                             input bit stop, output logic [11:0] f, output int unsigned n);
    f = '1;
    n = 0;
    f[n] = 1'b0; n++;
    for (int unsigned i = 0; i < DB; i++) begin
      f[n] = d[i]; n++;
    end
    if (mode == 2'd1 || mode == 2'd2) begin
      f[n] = ((mode == 2'd2) ? ~(^d) : (^d)) ^ bad; n++;
    end
    f[n] = stop; n++;
  endtask

  task automatic drive_bits(input logic [11:0] f, input int unsigned n, input bit scramble);
    for (int unsigned i = 0; i < n; i++) begin
      rx = f[i];
      wait_ticks(OS);
      // parity_mode must only matter at start detect
      if (scramble && i == 0) parity_mode = 2'($urandom_range(0, 3));
    end
  endtask

  typedef struct {
    logic [7:0]  d;
    logic [1:0]  mode;
    bit          bad;
    bit          stop;
    bit          rdy;
    logic [7:0]  e_data;
    bit          e_valid;
    int unsigned e_dv;
    int unsigned e_pe;
    int unsigned e_fe;
    int unsigned e_ov;
  } vec_t;

  // Bench view of the output register after the previous frame.
  logic [7:0] t_data  = 8'h00;
  bit         t_valid = 1'b0;

  // Reference: what one complete frame does to the output word, from the frame rules.
  function automatic void predict(inout vec_t v);
    bit par_on = (v.mode == 2'd1) || (v.mode == 2'd2);
    bit held   = t_valid && !v.rdy;
    v.e_dv = 0; v.e_pe = 0; v.e_fe = 0; v.e_ov = 0;
    v.e_data  = t_data;
    v.e_valid = held;
    if (!v.stop) begin
      v.e_fe = 1;
    end else if (held) begin
      v.e_ov = 1;
    end else begin
      v.e_data  = v.d;
      v.e_dv    = 1;
      v.e_pe    = (par_on && v.bad) ? 1 : 0;
      v.e_valid = !v.rdy;
    end
  endfunction

  task automatic run_frame(input vec_t v, input string tag);
    logic [11:0] f;
    int unsigned n;
    int unsigned pe0, fe0, ov0, dv0;
    bus.data_ready = v.rdy;
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_pre_valid"}, 32'(bus.data_valid), 32'(t_valid && !v.rdy));
    pe0 = pe_n; fe0 = fe_n; ov0 = ov_n; dv0 = dv_n;
    parity_mode = v.mode;
    build_frame(v.d, v.mode, v.bad, v.stop, f, n);
    drive_bits(f, n, 1'b1);
    rx = 1'b1;
    wait_ticks(40);
    check({tag, "_data"},  32'(bus.data),       32'(v.e_data));
    check({tag, "_valid"}, 32'(bus.data_valid), 32'(v.e_valid));
    check({tag, "_dv"},    dv_n - dv0, v.e_dv);
    check({tag, "_pe"},    pe_n - pe0, v.e_pe);
    check({tag, "_fe"},    fe_n - fe0, v.e_fe);
    check({tag, "_ov"},    ov_n - ov0, v.e_ov);
    check({tag, "_busy"},  32'(busy), 32'd0);
    t_data  = v.e_data;
    t_valid = v.e_valid;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [13];
    vec_t        v;
    logic [11:0] f;
    int unsigned n, pe0, fe0, ov0, dv0, bz0, ntick;
    bit          found, got, prev, t;

    // Data, mode, bad parity, stop value, ready | data, valid, dv, pe, fe, ov
    tbl[0]  = '{8'hA5, 2'd0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1, 0, 0, 0};
    tbl[1]  = '{8'h37, 2'd1, 1'b0, 1'b1, 1'b1, 8'h37, 1'b0, 1, 0, 0, 0};
    tbl[2]  = '{8'h37, 2'd1, 1'b1, 1'b1, 1'b1, 8'h37, 1'b0, 1, 1, 0, 0};
    tbl[3]  = '{8'h55, 2'd0, 1'b0, 1'b0, 1'b1, 8'h37, 1'b0, 0, 0, 1, 0};
    tbl[4]  = '{8'h0F, 2'd0, 1'b0, 1'b1, 1'b1, 8'h0F, 1'b0, 1, 0, 0, 0};
    tbl[5]  = '{8'h11, 2'd0, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1, 0, 0, 0};
    tbl[6]  = '{8'h22, 2'd0, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 0, 0, 0, 1};
    tbl[7]  = '{8'h3C, 2'd2, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1, 0, 0, 0};
    tbl[8]  = '{8'h3C, 2'd2, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1, 1, 0, 0};
    tbl[9]  = '{8'h81, 2'd3, 1'b0, 1'b1, 1'b1, 8'h81, 1'b0, 1, 0, 0, 0};
    tbl[10] = '{8'h6A, 2'd2, 1'b1, 1'b0, 1'b1, 8'h81, 1'b0, 0, 0, 1, 0};
    tbl[11] = '{8'h00, 2'd1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1, 0, 0, 0};
    tbl[12] = '{8'hFF, 2'd1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 0, 0, 0, 1};

    rst = 1'b1; enable = 1'b1; rx = 1'b1; parity_mode = 2'd0; bus.data_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_data",  32'(bus.data),       32'd0);
    check("rst_valid", 32'(bus.data_valid), 32'd0);
    check("rst_busy",  32'(busy),           32'd0);
    check("rst_pe",    32'(bus.parity_err), 32'd0);
    check("rst_fe",    32'(bus.frame_err),  32'd0);
    check("rst_ov",    32'(bus.overrun),    32'd0);
    rst = 1'b0;
    wait_ticks(4);

    for (int unsigned i = 0; i < 13; i++) run_frame(tbl[i], $sformatf("tbl%0d", i));

    // Short low pulse: start rejected as a glitch.
    pe0 = pe_n; fe0 = fe_n; ov0 = ov_n; dv0 = dv_n; bz0 = bz_n;
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(40);
    check("glitch_busy_pulse", bz_n - bz0, 32'd1);
    check("glitch_busy",       32'(busy), 32'd0);
    check("glitch_events",     (pe_n - pe0) + (fe_n - fe0) + (ov_n - ov0) + (dv_n - dv0), 32'd0);
    check("glitch_data",       32'(bus.data), 32'(t_data));

    // enable dropped mid-DATA with a pending word.
    dv0 = dv_n;
    parity_mode = 2'd0;
    build_frame(8'h5A, 2'd0, 1'b0, 1'b1, f, n);
    drive_bits(f, 3, 1'b0);
    rx = f[3];
    wait_ticks(5);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("en_busy",  32'(busy),           32'd0);
    check("en_data",  32'(bus.data),       32'(t_data));
    check("en_valid", 32'(bus.data_valid), 32'(t_valid));
    rx = 1'b1;
    wait_ticks(20);
    check("en_quiet_dv", dv_n - dv0, 32'd0);
    enable = 1'b1;
    bus.data_ready = 1'b1;
    @(posedge clk);
    #1;
    check("en_accept", 32'(bus.data_valid), 32'd0);
    t_valid = 1'b0;
    v = '{8'hC3, 2'd0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 0, 0, 0, 0};
    predict(v);
    run_frame(v, "en_next");

    // rst during DATA bit 3 with a pending word.
    v = '{8'h5A, 2'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0, 0, 0, 0};
    predict(v);
    run_frame(v, "pend");
    build_frame(8'h99, 2'd0, 1'b0, 1'b1, f, n);
    drive_bits(f, 4, 1'b0);
    rx = f[4];
    wait_ticks(8);
    pe0 = pe_n; fe0 = fe_n; ov0 = ov_n; dv0 = dv_n;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_data",  32'(bus.data),       32'd0);
    check("mid_rst_valid", 32'(bus.data_valid), 32'd0);
    check("mid_rst_busy",  32'(busy),           32'd0);
    t_data = 8'h00; t_valid = 1'b0;
    rx = 1'b1;
    wait_ticks(40);
    check("mid_rst_quiet", (pe_n - pe0) + (fe_n - fe0) + (ov_n - ov0) + (dv_n - dv0), 32'd0);
    v = '{8'hC3, 2'd1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0, 0, 0, 0};
    predict(v);
    run_frame(v, "rst_next");

    // Latency: ticks from start detect to the final stop decision, then one clk.
    bus.data_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    t_valid = 1'b0;
    parity_mode = 2'd0;
    build_frame(8'h96, 2'd0, 1'b0, 1'b1, f, n);
    found = 1'b0; got = 1'b0; prev = 1'b0; ntick = 0;
    fork
      drive_bits(f, n, 1'b0);
      begin
        for (int k = 0; k < 200; k++) begin
          @(posedge clk);
          #1;
          if (busy) begin found = 1'b1; break; end
        end
        if (found) begin
          for (int k = 0; k < 2000; k++) begin
            @(posedge clk);
            t = tick;
            #1;
            if (bus.data_valid) begin got = 1'b1; break; end
            if (t) ntick++;
            prev = t;
          end
        end
      end
    join
    check("lat_start_seen", 32'(found), 32'd1);
    check("lat_valid_seen", 32'(got),   32'd1);
    check("lat_ticks",      ntick, (1 + DB + 0 + SB - 1) * OS + OS / 2 + 1);
    check("lat_prev_tick",  32'(prev),  32'd1);
    check("lat_busy",       32'(busy),  32'd0);
    check("lat_data",       32'(bus.data), 32'h96);
    rx = 1'b1;
    wait_ticks(20);
    t_data = 8'h96;

    // Random frames against the reference.
    for (int unsigned i = 0; i < 25; i++) begin
      v.d    = 8'($urandom_range(0, 255));
      v.mode = 2'($urandom_range(0, 3));
      v.bad  = ($urandom_range(0, 3) == 0);
      v.stop = ($urandom_range(0, 5) != 0);
      v.rdy  = ($urandom_range(0, 1) == 1);
      predict(v);
      run_frame(v, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Parametrised, oversampling UART receiver. Successor to the fixed-format baud-clocked receiver.
- Runs on the system clock and is qualified by an oversample tick (OVERSAMPLE × baud) from the shared baud generator.
- Supports configurable data width, runtime parity mode, 1 or 2 stop bits, majority-vote sampling and a valid/ready output with overrun detection.
- Sits between the rx pin and the command/FIFO logic of the monitor FPGA.

Parameters:
- OVERSAMPLE, 16, ticks per bit; even, ≥8.
- DATA_BITS, 8, data bits per frame, 5..9, sent LSB first.
- STOP_BITS, 1, stop bits checked per frame, 1 or 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- tick  in  1  one-clk strobe at OVERSAMPLE × baud.
- enable  in  1  receiver enable.
- parity_mode  in  2  0 = none, 1 = even, 2 = odd, 3 = none. Latched at start of frame.
- rx  in  1  asynchronous rx line, idle high.
- data  out  DATA_BITS  received word.
- data_valid  out  1  word available; held until accepted.
- data_ready  in  1  consumer accepts the word when data_valid && data_ready.
- busy  out  1  frame in progress (state != IDLE).
- parity_err  out  1  one-clk pulse.
- frame_err  out  1  one-clk pulse.
- overrun  out  1  one-clk pulse.

Behaviour:
- Reset values: rx synchroniser = 1, state IDLE, all counters 0.
  - Outputs after reset: data = 0, data_valid = 0, busy = 0, all error pulses 0.
- rx passes through a 2-FF synchroniser (rx_s) before any use.
- All state and counter activity advances only on clk cycles with tick = 1, except the output handshake, which is per-clk.
- MID = OVERSAMPLE/2. A per-bit counter cnt runs 0..OVERSAMPLE-1.
- Sampling: rx_s is sampled at cnt = MID-1, MID and MID+1. The bit value is the 2-of-3 majority, decided at cnt = MID+1.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a tick with rx_s = 0 → START, cnt = 0, latch parity_mode.
  - START: at decision, bit = 1 (glitch) → IDLE with no outputs or errors; bit = 0 → continue. On wrap (cnt = OVERSAMPLE-1) → DATA, bit index = 0.
  - DATA: at decision, shift the bit into the shift register, LSB first. On wrap after bit DATA_BITS-1 → PARITY if parity is enabled, else STOP.
  - PARITY: at decision, compare against the XOR of the data bits (even: XOR = bit; odd: XOR ≠ bit) and latch the mismatch. On wrap → STOP.
  - STOP: at each decision, a 0 sets the frame-error latch. A non-final stop bit wraps to the next stop bit. At the decision of the final stop bit: complete the frame → IDLE, allowing back-to-back start detection within half a bit.
- Frame completion, applied on the clk after the final stop decision tick:
  - frame_err latched: pulse frame_err; data is not loaded and data_valid is unchanged.
  - Otherwise, if data_valid = 1 and data_ready = 0 in that same cycle: pulse overrun, discard the new word and keep the old one.
  - Otherwise: load data, set data_valid = 1, and pulse parity_err if the mismatch was latched (the word is still delivered).
- Acceptance: data_valid && data_ready clears data_valid next clk.
  - Simultaneous accept and completion: the new word loads, data_valid stays 1, and no overrun is raised.
- enable = 0: state → IDLE on the next clk, regardless of tick. A frame in progress is aborted silently. data and data_valid are retained and the handshake keeps working.
- rst mid-frame: everything returns to reset values on the next clk, including dropping a pending data_valid.
- Latency: data_valid rises 1 clk after the tick on which the final stop bit is decided. That tick is ((1 + DATA_BITS + P + STOP_BITS - 1) × OVERSAMPLE + MID + 1) ticks after the start-detect tick, where P is 1 with parity and 0 without.

Decomposition:
- Shared package uart_pkg:
  - state enum rx_state_t (IDLE, START, DATA, PARITY, STOP).
  - parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD.
  - default OVERSAMPLE and DATA_BITS constants.
  - These are shared with the future uart_tx successor.
- Sub-module uart_rx_sampler:
  - 2-FF synchroniser, 3-sample majority vote and cnt, producing bit value, decision strobe and wrap strobe.
  - The FSM in uart_rx_os consumes those strobes.

Test Plan:
- 8N1, OVERSAMPLE = 16, frame 0xA5, data_ready = 1 → data = 0xA5, data_valid for 1 clk, no errors, busy low after the stop bit.
- Even parity, frame 0x37 with parity bit 1 → data 0x37, parity_err = 0. Same frame with parity bit 0 → data 0x37 delivered and parity_err pulses once.
- Stop bit driven 0, frame 0x55 → frame_err pulses, data_valid stays 0, receiver re-arms and the next frame 0x0F is received correctly.
- rx low for 4 ticks then high → busy pulses and returns to IDLE, with no data_valid and no error pulses.
- Two frames 0x11 then 0x22, data_ready = 0 → data stays 0x11 and overrun pulses once. Then assert data_ready → data_valid clears.
- rst asserted during DATA bit 3, and separately enable dropped during DATA → outputs return to reset values (rst) or data/data_valid are retained (enable). The following frame 0xC3 is received correctly in both cases.
